dma_arbiter_guard: RTL and testbench
====================================

# dma_arbiter_guard

Two-master DMA arbiter and access guard in front of the openMSP430 DMA port. It shares the single DMA interface between two requesters using round-robin arbitration with bounded bursts. Every beat is screened against the secure-data (SDATA) and counter (CTR) regions. Any hit suppresses the access, latches a kill state and raises a reset request that holds until the CPU reaches the reset handler.

## Interface
- SDATA_BASE, 16'hA000, first address of secure-data region
- SDATA_SIZE, 16'h1000, size of secure-data region in bytes
- CTR_BASE, 16'h9000, first address of counter region
- CTR_SIZE, 16'h0020, size of counter region in bytes
- RESET_HANDLER, 16'h0000, PC value that releases KILL
- MAX_BURST, 4, max consecutive grants per tenure (1..15)
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- pc  in  16  current CPU program counter
- req0, req1  in  1  requester 0/1 transfer request; held until grant
- addr0, addr1  in  16  requester 0/1 beat address; stable while req high
- we0, we1  in  1  requester 0/1 write enable
- dma_ready  in  1  CPU DMA port accepted the current beat
- dma_en  out  1  DMA beat valid
- dma_addr  out  16  DMA beat address
- dma_we  out  1  DMA beat write enable
- gnt0, gnt1  out  1  one-cycle pulse: beat of requester 0/1 completed
- violation  out  1  reset request to the CPU; high in KILL

## Operation
- Region hit: hit = (a >= SDATA_BASE && a < SDATA_BASE+SDATA_SIZE) || (a >= CTR_BASE && a < CTR_BASE+CTR_SIZE). Compare in 17 bits so BASE+SIZE does not wrap. Reads and writes are treated alike.
- States: IDLE, BUSY0, BUSY1, KILL. Registers: state, rr_ptr (1 bit, favoured master), burst_cnt (4 bits).
- IDLE:
  - Selection: if only one requester has req high, it is selected. If both are high, the requester equal to rr_ptr is selected.
  - If the selected address hits → KILL.
  - Otherwise → BUSYx with burst_cnt=0.
  - With no req → stay in IDLE.
- BUSYx:
  - dma_addr=addrx, dma_we=wex, dma_en = !hit(addrx).
  - If hit(addrx) → KILL next edge, with no grant.
  - Else, if dma_ready → gntx=1 and burst_cnt++. Leave for IDLE when either reqx is low in the grant cycle or burst_cnt reaches MAX_BURST-1; on leaving, set rr_ptr = other master. Otherwise stay in BUSYx, and the requester presents its next beat address in the following cycle.
  - If reqx drops without a grant → IDLE, rr_ptr unchanged.
- KILL:
  - violation=1, dma_en=0, no grants, requests ignored.
  - When pc==RESET_HANDLER and neither addr0 with req0 nor addr1 with req1 hits → IDLE, rr_ptr=0.
- Outside BUSYx: dma_en=0, dma_addr=0, dma_we=0.

## Timing
- Reset (reset_n low at edge): state=KILL, rr_ptr=0, burst_cnt=0. Outputs in the cycle after: violation=1, dma_en=0, gnt0=gnt1=0, dma_addr=0, dma_we=0.
- Request latency: req seen in IDLE at edge t → dma_en high in cycle t+1. Minimum 1 cycle request-to-grant beyond dma_ready.
- gntx and violation are decoded from registered state plus dma_ready, not registered outputs. gntx is high only in cycles where state=BUSYx && dma_ready && !hit.
- Protected hit in BUSYx masks dma_en in the same cycle (combinational) and sets violation from the next cycle.
- Between tenures there is always at least one IDLE cycle, including back-to-back same-master tenures.
- reset_n low mid-burst aborts immediately: no grant in the reset cycle, KILL afterward.
- Simultaneous hit and dma_ready: the hit wins, with no grant.
- pc==RESET_HANDLER while a requester holds a hitting address: remain in KILL.

## Test plan
- Reset release: reset_n low 2 cycles, then high with pc=16'h0000 and no req → violation=1 for 1 cycle after reset, IDLE next, violation=0, dma_en=0.
- Single transfer: req0=1, addr0=16'h0200, we0=1, dma_ready=1 constant → dma_en=1, dma_addr=16'h0200 one cycle after req. gnt0 pulses once. Drop req0 → IDLE. rr_ptr=1.
- Round-robin and burst: req0 and req1 held high, dma_ready=1, MAX_BURST=4 → pattern of 4 gnt0, one IDLE cycle, 4 gnt1, one IDLE cycle, 4 gnt0.
- Wait states: dma_ready low 3 cycles during BUSY1 → dma_en and dma_addr held. gnt1 pulses only in the cycle dma_ready=1.
- SDATA hit mid-burst: second beat addr0=16'hA010 → dma_en=0 that cycle, no gnt0, violation=1 next cycle. It stays 1 with pc=16'h0100 and clears one cycle after pc=16'h0000 with no hitting req.
- CTR boundary: addr1=16'h901F → KILL. addr1=16'h9020 → normal grant. addr0=16'hFFFF with SDATA_BASE=16'hF000, SDATA_SIZE=16'h1000 → KILL (no wrap).

Source files
------------

// File: rtl/dma_arbiter_guard_if.sv
// Bundles the requester, CPU-side DMA and guard signals of the two-master DMA arbiter.
// The master side drives requests, pc and dma_ready; the slave side is the arbiter.
interface dma_arbiter_guard_if;
    logic [15:0] pc;
    logic        req0;
    logic        req1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic        we0;
    logic        we1;
    logic        dma_ready;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic        gnt0;
    logic        gnt1;
    logic        violation;

    modport master (
        output pc, req0, req1, addr0, addr1, we0, we1, dma_ready,
        input  dma_en, dma_addr, dma_we, gnt0, gnt1, violation
    );

    modport slave (
        input  pc, req0, req1, addr0, addr1, we0, we1, dma_ready,
        output dma_en, dma_addr, dma_we, gnt0, gnt1, violation
    );
endinterface

// File: rtl/dma_arbiter_guard.sv
// Round-robin, burst-bounded arbiter sharing the openMSP430 DMA port between two masters.
// It also screens every beat against the SDATA/CTR regions and traps into KILL on any hit.
module dma_arbiter_guard #(
    parameter logic [15:0] SDATA_BASE    = 16'hA000,
    parameter logic [15:0] SDATA_SIZE    = 16'h1000,
    parameter logic [15:0] CTR_BASE      = 16'h9000,
    parameter logic [15:0] CTR_SIZE      = 16'h0020,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          MAX_BURST     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    dma_arbiter_guard_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, KILL} state_t;

    // Region bounds are widened to 17 bits so BASE+SIZE at the top of memory cannot wrap.
    localparam logic [16:0] SD_LO  = {1'b0, SDATA_BASE};
    localparam logic [16:0] SD_HI  = {1'b0, SDATA_BASE} + {1'b0, SDATA_SIZE};
    localparam logic [16:0] CTR_LO = {1'b0, CTR_BASE};
    localparam logic [16:0] CTR_HI = {1'b0, CTR_BASE} + {1'b0, CTR_SIZE};
    localparam logic [3:0]  LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;

    logic        hit0, hit1;
    logic        sel;
    logic        sel_hit;
    logic [15:0] cur_addr;
    logic        cur_hit;
    logic        cur_req;
    logic        cur_we;

    logic        dma_en_c;
    logic [15:0] dma_addr_c;
    logic        dma_we_c;
    logic        gnt0_c;
    logic        gnt1_c;
    logic        violation_c;

    function automatic logic region_hit(input logic [15:0] a);
        logic [16:0] a17;
        a17 = {1'b0, a};
        return ((a17 >= SD_LO) && (a17 < SD_HI)) || ((a17 >= CTR_LO) && (a17 < CTR_HI));
    endfunction

    assign hit0     = region_hit(bus.addr0);
    assign hit1     = region_hit(bus.addr1);
    assign sel      = (bus.req0 && bus.req1) ? rr_ptr_q : bus.req1;
    assign sel_hit  = sel ? hit1 : hit0;
    assign cur_addr = (state_q == BUSY1) ? bus.addr1 : bus.addr0;
    assign cur_hit  = (state_q == BUSY1) ? hit1 : hit0;
    assign cur_req  = (state_q == BUSY1) ? bus.req1 : bus.req0;
    assign cur_we   = (state_q == BUSY1) ? bus.we1 : bus.we0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        dma_en_c    = 1'b0;
        dma_addr_c  = 16'h0000;
        dma_we_c    = 1'b0;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        violation_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (sel_hit) begin
                        state_d = KILL;
                    end else begin
                        state_d     = sel ? BUSY1 : BUSY0;
                        burst_cnt_d = 4'd0;
                    end
                end
            end
            BUSY0, BUSY1: begin
                dma_addr_c = cur_addr;
                dma_we_c   = cur_we;
                dma_en_c   = !cur_hit && reset_n;
                if (cur_hit) begin
                    state_d     = KILL;
                    burst_cnt_d = 4'd0;
                end else if (bus.dma_ready) begin
                    // Reset asserted mid-burst aborts the beat: no grant in that cycle.
                    gnt0_c      = (state_q == BUSY0) && reset_n;
                    gnt1_c      = (state_q == BUSY1) && reset_n;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (!cur_req || (burst_cnt_q == LAST_BEAT)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = (state_q == BUSY0);
                        burst_cnt_d = 4'd0;
                    end
                end else if (!cur_req) begin
                    state_d = IDLE;
                end
            end
            KILL: begin
                violation_c = 1'b1;
                if ((bus.pc == RESET_HANDLER) && !(bus.req0 && hit0) && !(bus.req1 && hit1)) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b0;
                end
            end
            default: begin
                state_d = KILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= KILL;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.dma_en    = dma_en_c;
    assign bus.dma_addr  = dma_addr_c;
    assign bus.dma_we    = dma_we_c;
    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.violation = violation_c;

endmodule

// File: tb/tb_dma_arbiter_guard.sv
// Bench for dma_arbiter_guard: directed scenarios plus random traffic compared cycle by
// cycle against a tenure-level reference model; a second instance covers a top-of-memory region.
module tb_dma_arbiter_guard;

    localparam int SD_B = 32'hA000;
    localparam int SD_S = 32'h1000;
    localparam int CT_B = 32'h9000;
    localparam int CT_S = 32'h0020;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: who owns the port, beats granted so far, favoured master, trap flag.
    int   m_owner;
    int   m_beats;
    bit   m_fav;
    bit   m_killed;
    logic [31:0] obs;
    logic [29:0] pat_got, pat_exp;
    int   cnt;

    always #5 clk = ~clk;

    dma_arbiter_guard_if u_if ();
    dma_arbiter_guard_if u_if2 ();

    dma_arbiter_guard u_dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (u_if)
    );

    dma_arbiter_guard #(
        .SDATA_BASE (16'hF000),
        .SDATA_SIZE (16'h1000)
    ) u_dut_top (
        .clk     (clk),
        .reset_n (rst2_n),
        .bus     (u_if2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_hit(input int a);
        return (a >= SD_B && a < SD_B + SD_S) || (a >= CT_B && a < CT_B + CT_S);
    endfunction

    task automatic model_update();
        int  a;
        bit  r;
        int  pick;
        if (!rst_n) begin
            m_killed = 1; m_owner = -1; m_fav = 0; m_beats = 0;
        end else if (m_killed) begin
            if (u_if.pc == 16'h0000 && !(u_if.req0 && ref_hit(int'(u_if.addr0)))
                                    && !(u_if.req1 && ref_hit(int'(u_if.addr1)))) begin
                m_killed = 0; m_fav = 0;
            end
        end else if (m_owner < 0) begin
            if (u_if.req0 || u_if.req1) begin
                pick = (u_if.req0 && u_if.req1) ? int'(m_fav) : (u_if.req1 ? 1 : 0);
                if (ref_hit(pick == 1 ? int'(u_if.addr1) : int'(u_if.addr0))) m_killed = 1;
                else begin m_owner = pick; m_beats = 0; end
            end
        end else begin
            a = (m_owner == 1) ? int'(u_if.addr1) : int'(u_if.addr0);
            r = (m_owner == 1) ? u_if.req1 : u_if.req0;
            if (ref_hit(a)) begin
                m_killed = 1; m_owner = -1;
            end else if (u_if.dma_ready) begin
                m_beats++;
                if (!r || m_beats == MAXB) begin
                    m_fav = (m_owner == 0); m_owner = -1;
                end
            end else if (!r) begin
                m_owner = -1;
            end
        end
    endtask

    // Sample mid-cycle, compare every output with the model, advance the model, go to next negedge.
    task automatic cyc(input string tag);
        int a;
        bit h, en, we, g0, g1;
        logic [15:0] ad;
        #1;
        en = 0; we = 0; g0 = 0; g1 = 0; ad = 16'h0000;
        if (!m_killed && m_owner >= 0) begin
            a  = (m_owner == 1) ? int'(u_if.addr1) : int'(u_if.addr0);
            h  = ref_hit(a);
            ad = a[15:0];
            we = (m_owner == 1) ? u_if.we1 : u_if.we0;
            if (rst_n && !h) begin
                en = 1;
                if (u_if.dma_ready) begin
                    g0 = (m_owner == 0);
                    g1 = (m_owner == 1);
                end
            end
        end
        obs = {11'd0, u_if.violation, u_if.dma_en, u_if.dma_we, u_if.gnt0, u_if.gnt1, u_if.dma_addr};
        check_eq(tag, obs, {11'd0, m_killed, en, we, g0, g1, ad});
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 11))
            0:       return 16'h8FFC + 16'($urandom_range(0, 40));
            1:       return 16'h9FFC + 16'($urandom_range(0, 8));
            2:       return 16'hAFFC + 16'($urandom_range(0, 8));
            default: return 16'($urandom_range(0, 16'h8FFF));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        u_if.pc = 16'h0100; u_if.req0 = 0; u_if.req1 = 0; u_if.addr0 = 0; u_if.addr1 = 0;
        u_if.we0 = 0; u_if.we1 = 0; u_if.dma_ready = 0;
        u_if2.pc = 16'h0100; u_if2.req0 = 0; u_if2.req1 = 0; u_if2.addr0 = 0; u_if2.addr1 = 0;
        u_if2.we0 = 0; u_if2.we1 = 0; u_if2.dma_ready = 0;
        m_killed = 1; m_owner = -1; m_fav = 0; m_beats = 0;

        // Reset low two cycles, then release with pc at the handler.
        @(posedge clk); @(negedge clk);
        cyc("rst_low");
        check_eq("rst_viol", 32'(obs[20]), 32'd1);
        rst_n = 1'b1; u_if.pc = 16'h0000;
        cyc("rst_rel");
        check_eq("rel_viol", 32'(obs[20]), 32'd1);
        cyc("idle");
        check_eq("idle_viol", 32'(obs[20]), 32'd0);
        check_eq("idle_en", 32'(obs[19]), 32'd0);

        // Single transfer from master 0.
        u_if.req0 = 1; u_if.addr0 = 16'h0200; u_if.we0 = 1; u_if.dma_ready = 1;
        cyc("st_req");
        u_if.req0 = 0;
        cyc("st_beat");
        check_eq("st_en_addr", {15'd0, obs[19], obs[15:0]}, {15'd0, 1'b1, 16'h0200});
        check_eq("st_gnt0", 32'(obs[17]), 32'd1);
        cyc("st_idle");
        check_eq("st_idle_gnt", 32'(obs[17]), 32'd0);

        // Both masters held: favoured master is now 1, bursts of MAXB with an IDLE gap.
        u_if.req0 = 1; u_if.addr0 = 16'h0400; u_if.req1 = 1; u_if.addr1 = 16'h0500; u_if.we1 = 0;
        for (int c = 0; c < 15; c++) begin
            cyc("rr");
            pat_got[2*c +: 2] = {obs[16], obs[17]};
            pat_exp[2*c +: 2] = ((c >= 1 && c <= 4) || (c >= 11)) ? 2'b10 :
                                (c >= 6 && c <= 9) ? 2'b01 : 2'b00;
        end
        check_eq("rr_pattern", 32'(pat_got), 32'(pat_exp));

        // Wait states during BUSY1.
        u_if.req0 = 0; u_if.req1 = 1; u_if.addr1 = 16'h1234; u_if.dma_ready = 0;
        cyc("ws_idle");
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc("ws_wait");
            if (obs[19] && obs[15:0] == 16'h1234 && !obs[16]) cnt++;
        end
        check_eq("ws_held", 32'(cnt), 32'd3);
        u_if.dma_ready = 1; u_if.req1 = 0;
        cyc("ws_gnt");
        check_eq("ws_gnt1", 32'(obs[16]), 32'd1);
        cyc("ws_done");

        // SDATA hit on the second beat of a burst.
        u_if.req0 = 1; u_if.addr0 = 16'h0300; u_if.pc = 16'h0100;
        cyc("sd_req");
        cyc("sd_b1");
        u_if.addr0 = 16'hA010;
        cyc("sd_hit");
        check_eq("sd_hit_out", {29'd0, obs[20], obs[19], obs[17]}, 32'd0);
        u_if.req0 = 0;
        cyc("sd_k1");
        check_eq("sd_viol1", 32'(obs[20]), 32'd1);
        cyc("sd_k2");
        check_eq("sd_viol_pc", 32'(obs[20]), 32'd1);
        u_if.pc = 16'h0000;
        cyc("sd_rel");
        check_eq("sd_viol_rel", 32'(obs[20]), 32'd1);
        cyc("sd_clr");
        check_eq("sd_viol_clr", 32'(obs[20]), 32'd0);

        // CTR region boundaries.
        u_if.req1 = 1; u_if.addr1 = 16'h901F;
        cyc("ctr_last");
        cyc("ctr_kill");
        check_eq("ctr_viol", 32'(obs[20]), 32'd1);
        u_if.req1 = 0;
        cyc("ctr_rel");
        cyc("ctr_idle");
        u_if.req1 = 1; u_if.addr1 = 16'h9020;
        cyc("ctr_req");
        u_if.req1 = 0;
        cyc("ctr_beat");
        check_eq("ctr_above", {15'd0, obs[16], obs[15:0]}, {15'd0, 1'b1, 16'h9020});
        cyc("ctr_done");

        // Reset asserted mid-burst, then a hitting request blocks release.
        u_if.req0 = 1; u_if.addr0 = 16'h0600;
        cyc("rb_req");
        cyc("rb_b1");
        rst_n = 1'b0;
        cyc("rb_rst");
        check_eq("rb_no_gnt", {30'd0, obs[19], obs[17]}, 32'd0);
        rst_n = 1'b1; u_if.addr0 = 16'hA000;
        cyc("rb_k1");
        cyc("rb_k2");
        check_eq("rb_hold", 32'(obs[20]), 32'd1);
        u_if.req0 = 0;
        cyc("rb_rel");
        cyc("rb_idle");
        check_eq("rb_idle_viol", 32'(obs[20]), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            u_if.req0 = $urandom_range(0, 1);
            u_if.req1 = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) u_if.addr0 = rand_addr();
            if ($urandom_range(0, 3) == 0) u_if.addr1 = rand_addr();
            u_if.we0 = $urandom_range(0, 1);
            u_if.we1 = $urandom_range(0, 1);
            u_if.dma_ready = ($urandom_range(0, 9) < 7);
            u_if.pc = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
            cyc("rand");
        end

        // Region ending exactly at the top of memory must not wrap.
        rst2_n = 1'b1; u_if2.pc = 16'h0000;
        #1;
        check_eq("top_rel_viol", 32'(u_if2.violation), 32'd1);
        @(negedge clk); #1;
        check_eq("top_idle_viol", 32'(u_if2.violation), 32'd0);
        u_if2.req0 = 1; u_if2.addr0 = 16'hFFFF; u_if2.dma_ready = 1;
        #1;
        check_eq("top_en", 32'(u_if2.dma_en), 32'd0);
        @(negedge clk); #1;
        check_eq("top_kill", {30'd0, u_if2.violation, u_if2.gnt0}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
